// File: rtl/ixc_ofifo_tx.sv
// ixc_ofifo_tx: buffers design words and frames them into credit-limited packets
// (one header word plus 1..MAXPKT payload words) for the host stream.
module ixc_ofifo_tx #(
    parameter int          DW     = 512,
    parameter int          BDEPTH = 32,
    parameter int          MAXPKT = 16,
    parameter int          WINDOW = 65536,
    parameter logic [15:0] TID    = 16'h0000,
    parameter logic [11:0] ODLY   = 12'd255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          srcValid,
    input  logic [DW-1:0] srcData,
    input  logic          srcEob,
    output logic          srcReady,
    output logic          oValid,
    output logic [DW-1:0] oData,
    output logic          oSop,
    output logic          oEop,
    input  logic          oReady,
    input  logic          ackValid,
    input  logic [17:0]   ackLen,
    output logic [16:0]   inFlight,
    output logic          ackErr
);
    localparam int AW = $clog2(BDEPTH);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
    state_t state, stateNext;
    logic [DW-1:0] mem [BDEPTH];
    logic [BDEPTH-1:0] eobMem;
    logic [16:0] wptr, rptr, occ;
    logic [15:0] pktl, pktlNext, remCnt, eobDist;
    logic [31:0] seq;
    logic [11:0] idleCnt;
    logic [17:0] credSum;
    logic eobHit, wr, rd, hdrAcc, launch, ackOver;
    assign occ = wptr - rptr;
    assign srcReady = !reset && occ < 17'(BDEPTH);
    assign wr = srcValid && srcReady;
    assign rd = state == DATA && oReady;
    assign hdrAcc = state == HDR && oReady;
    // the nearest buffered EOB within one packet's reach closes the packet there
    always_comb begin
        eobHit = 1'b0;
        eobDist = '0;
        for (int i = MAXPKT - 1; i >= 0; i--)
            if (eobMem[rptr[AW-1:0] + AW'(i)] && 17'(i) < occ) begin
                eobHit = 1'b1;
                eobDist = 16'(i);
            end
    end
    assign pktlNext = eobHit ? eobDist + 16'd1 : occ >= 17'(MAXPKT) ? 16'(MAXPKT) : occ[15:0];
    assign launch = state == IDLE && (occ >= 17'(MAXPKT) || eobHit || (idleCnt == ODLY && occ != '0))
                    && 18'(inFlight) + 18'(pktlNext) <= 18'(WINDOW);
    assign credSum = 18'(inFlight) + (hdrAcc ? 18'(pktl) : 18'd0);
    assign ackOver = ackValid && ackLen > credSum;
    always_comb begin
        stateNext = state;
        oValid = state == HDR || state == DATA;
        oSop = state == HDR;
        oEop = state == DATA && remCnt == 16'd1;
        oData = state == HDR ? DW'({seq, TID, pktl}) : state == DATA ? mem[rptr[AW-1:0]] : '0;
        case (state)
            IDLE:    stateNext = launch ? HDR : IDLE;
            HDR:     stateNext = oReady ? DATA : HDR;
            DATA:    stateNext = oReady && remCnt == 16'd1 ? IDLE : DATA;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= srcData;
            eobMem[wptr[AW-1:0]] <= srcEob;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wptr <= '0;
            rptr <= '0;
            pktl <= '0;
            remCnt <= '0;
            seq <= '0;
            idleCnt <= '0;
            inFlight <= '0;
            ackErr <= 1'b0;
        end else begin
            state <= stateNext;
            if (wr) wptr <= wptr + 17'd1;
            if (rd) rptr <= rptr + 17'd1;
            if (launch) begin
                pktl <= pktlNext;
                remCnt <= pktlNext;
            end else if (rd) remCnt <= remCnt - 16'd1;
            if (hdrAcc) seq <= seq + 32'd1;
            idleCnt <= wr || launch ? '0 : idleCnt == ODLY ? idleCnt : idleCnt + 12'd1;
            inFlight <= ackOver ? '0 : ackValid ? 17'(credSum - ackLen) : credSum[16:0];
            if (ackOver) ackErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ixc_ofifo_tx.sv
// tb_ixc_ofifo_tx: directed scenarios plus a randomized run against a queue-based packetizer model.
module tb_ixc_ofifo_tx;
    localparam int DW = 512, BDEPTH = 32, MAXPKT = 16, WINDOW = 32, ODLY = 255;
    logic clk = 1'b0, reset, srcValid, srcEob, srcReady, oValid, oSop, oEop, oReady, ackValid, ackErr;
    logic [DW-1:0] srcData, oData;
    logic [17:0] ackLen;
    logic [16:0] inFlight;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    ixc_ofifo_tx #(.WINDOW(WINDOW)) dut (
        .clk(clk), .reset(reset), .srcValid(srcValid), .srcData(srcData), .srcEob(srcEob),
        .srcReady(srcReady), .oValid(oValid), .oData(oData), .oSop(oSop), .oEop(oEop),
        .oReady(oReady), .ackValid(ackValid), .ackLen(ackLen), .inFlight(inFlight), .ackErr(ackErr)
    );

    typedef struct { logic [DW-1:0] d; bit e; } word_t;
    word_t bufQ[$];
    bit mHdr, mErr, expValid, expSop, expEop, expReady;
    int mRem, mPktl, mIdle, mInFl;
    logic [31:0] mSeq;
    logic [DW-1:0] expData;
    logic [DW-1:0] got[$];

    function automatic logic [DW-1:0] hdrWord(input logic [31:0] s, input int p);
        return DW'({s, 16'h0000, 16'(p)});
    endfunction

    // reference packetizer: words in a queue, packets cut by the launch/credit rules
    always @(posedge clk) begin
        int occ, p, fe, s;
        bit go, hAcc, dAcc, wrOk;
        if (reset) begin
            bufQ.delete();
            mHdr = 0; mRem = 0; mPktl = 0; mIdle = 0; mInFl = 0; mErr = 0; mSeq = 0;
        end else begin
            occ = bufQ.size();
            p = occ < MAXPKT ? occ : MAXPKT;
            fe = -1;
            for (int i = 0; i < p; i++) if (bufQ[i].e && fe < 0) fe = i;
            if (fe >= 0) p = fe + 1;
            go = !mHdr && mRem == 0 && (occ >= MAXPKT || fe >= 0 || (mIdle == ODLY && occ > 0)) && mInFl + p <= WINDOW;
            hAcc = mHdr && oReady;
            dAcc = !mHdr && mRem > 0 && oReady;
            wrOk = srcValid && occ < BDEPTH;
            s = mInFl + (hAcc ? mPktl : 0);
            if (ackValid) begin
                if (int'(ackLen) > s) begin s = 0; mErr = 1; end
                else s -= int'(ackLen);
            end
            mInFl = s;
            if (hAcc) begin mHdr = 0; mSeq++; end
            if (dAcc) begin void'(bufQ.pop_front()); mRem--; end
            if (wrOk) bufQ.push_back('{srcData, srcEob});
            if (go) begin mHdr = 1; mRem = p; mPktl = p; end
            mIdle = (wrOk || go) ? 0 : (mIdle < ODLY ? mIdle + 1 : mIdle);
        end
        expReady = !reset && bufQ.size() < BDEPTH;
        expValid = mHdr || mRem > 0;
        expSop = mHdr;
        expEop = !mHdr && mRem == 1;
        expData = mHdr ? hdrWord(mSeq, mPktl) : (mRem > 0 ? bufQ[0].d : '0);
    end

    task automatic tick; @(negedge clk); endtask

    task automatic push(input int n, input int base, input bit eobLast);
        for (int i = 0; i < n; i++) begin
            srcValid = 1; srcData = DW'(base + i); srcEob = eobLast && i == n - 1; tick();
        end
        srcValid = 0; srcEob = 0;
    endtask

    task automatic ack(input int len);
        ackValid = 1; ackLen = 18'(len); tick(); ackValid = 0; ackLen = '0;
    endtask

    task automatic drain;
        int n = 0;
        oReady = 1;
        while (!oValid && n < 400) begin tick(); n++; end
        while (oValid && n < 800) begin tick(); n++; end
        checks++; if (n >= 400 && oValid) begin errors++; $display("FAIL drain_timeout got %0d cycles want <800", n); end
    endtask

    task automatic test_reset;
        reset = 1; srcValid = 0; srcData = '0; srcEob = 0; oReady = 0; ackValid = 0; ackLen = '0;
        repeat (3) tick();
        checks++; if (srcReady !== 1'b0) begin errors++; $display("FAIL reset_srcReady got %b want 0", srcReady); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid got %b want 0", oValid); end
        checks++; if (oSop !== 1'b0 || oEop !== 1'b0) begin errors++; $display("FAIL reset_sop_eop got %b%b want 00", oSop, oEop); end
        checks++; if (oData !== '0) begin errors++; $display("FAIL reset_oData got %h want 0", oData); end
        checks++; if (inFlight !== 17'd0) begin errors++; $display("FAIL reset_inFlight got %0d want 0", inFlight); end
        checks++; if (ackErr !== 1'b0) begin errors++; $display("FAIL reset_ackErr got %b want 0", ackErr); end
        reset = 0; tick();
        checks++; if (srcReady !== 1'b1) begin errors++; $display("FAIL reset_release_srcReady got %b want 1", srcReady); end
    endtask

    task automatic test_full_packet;
        oReady = 1;
        push(16, 0, 0);
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL full_latency_early got %b want 0", oValid); end
        tick();
        checks++; if (oSop !== 1'b1 || oData !== hdrWord(0, 16)) begin errors++; $display("FAIL full_header got sop=%b %h want sop=1 %h", oSop, oData[63:0], hdrWord(0, 16)); end
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (oValid !== 1'b1 || oSop !== 1'b0 || oData !== DW'(k) || oEop !== (k == 15)) begin
                errors++; $display("FAIL full_payload%0d got v=%b sop=%b eop=%b %0h want %0h", k, oValid, oSop, oEop, oData, k);
            end
        end
        tick();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL full_after got %b want 0", oValid); end
        checks++; if (inFlight !== 17'd16) begin errors++; $display("FAIL full_inFlight got %0d want 16", inFlight); end
        ack(16);
        checks++; if (inFlight !== 17'd0) begin errors++; $display("FAIL full_ack got %0d want 0", inFlight); end
    endtask

    task automatic test_eob;
        oReady = 1;
        push(3, 100, 1);
        tick();
        checks++; if (oSop !== 1'b1 || oData !== hdrWord(1, 3)) begin errors++; $display("FAIL eob_header got sop=%b %h want %h", oSop, oData[63:0], hdrWord(1, 3)); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (oData !== DW'(100 + k) || oEop !== (k == 2)) begin errors++; $display("FAIL eob_payload%0d got eop=%b %0h want %0h", k, oEop, oData, 100 + k); end
        end
        tick();
        checks++; if (inFlight !== 17'd3) begin errors++; $display("FAIL eob_inFlight got %0d want 3", inFlight); end
        ack(3);
    endtask

    task automatic test_timeout;
        int n = 0;
        oReady = 1;
        push(2, 200, 0);
        while (!oSop && n < 400) begin tick(); n++; end
        checks++; if (n !== ODLY + 1) begin errors++; $display("FAIL timeout_delay got %0d want %0d", n, ODLY + 1); end
        checks++; if (oData !== hdrWord(2, 2)) begin errors++; $display("FAIL timeout_header got %h want %h", oData[63:0], hdrWord(2, 2)); end
        drain();
        checks++; if (inFlight !== 17'd2) begin errors++; $display("FAIL timeout_inFlight got %0d want 2", inFlight); end
        ack(2);
    endtask

    task automatic test_window;
        bit saw = 0;
        push(16, 300, 0); drain();
        push(16, 400, 0); drain();
        checks++; if (inFlight !== 17'd32) begin errors++; $display("FAIL window_full got %0d want 32", inFlight); end
        push(16, 500, 0);
        repeat (300) begin tick(); if (oValid) saw = 1; end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL window_blocked got header want none"); end
        ack(16);
        checks++; if (inFlight !== 17'd16) begin errors++; $display("FAIL window_ack got %0d want 16", inFlight); end
        tick();
        checks++; if (oSop !== 1'b1 || oData !== hdrWord(5, 16)) begin errors++; $display("FAIL window_release got sop=%b %h want %h", oSop, oData[63:0], hdrWord(5, 16)); end
        drain();
        ack(32);
    endtask

    task automatic test_backpressure;
        bit stalled = 0, done = 0;
        logic [DW-1:0] held;
        got.delete();
        oReady = 1;
        push(16, 600, 0);
        for (int c = 0; c < 100 && !done; c++) begin
            if (oValid && !oSop && got.size() == 3 && !stalled) begin
                stalled = 1; oReady = 0; held = oData;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    checks++; if (oValid !== 1'b1 || oData !== held) begin errors++; $display("FAIL stall_hold%0d got %0h want %0h", j, oData, held); end
                end
                oReady = 1;
            end
            if (oValid && !oSop) begin got.push_back(oData); done = oEop; end
            tick();
        end
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL stall_count got %0d want 16", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== DW'(600 + k)) begin errors++; $display("FAIL stall_word%0d got %0h want %0h", k, got[k], 600 + k); end
        end
        ack(16);
    endtask

    task automatic test_full_buffer;
        int acc = 0, hdrCnt = 0, eops = 0;
        oReady = 0;
        for (int i = 0; i < 33; i++) begin
            srcValid = 1; srcData = DW'(700 + acc);
            if (srcReady) acc++;
            tick();
        end
        srcValid = 0;
        checks++; if (acc !== 32) begin errors++; $display("FAIL fill_accepted got %0d want 32", acc); end
        checks++; if (srcReady !== 1'b0) begin errors++; $display("FAIL fill_srcReady got %b want 0", srcReady); end
        got.delete();
        oReady = 1;
        for (int c = 0; c < 200 && eops < 2; c++) begin
            if (oValid) begin
                if (oSop) hdrCnt++; else got.push_back(oData);
                if (oEop) eops++;
            end
            tick();
        end
        checks++; if (hdrCnt !== 2 || got.size() !== 32) begin errors++; $display("FAIL fill_drain got hdr=%0d words=%0d want 2/32", hdrCnt, got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== DW'(700 + k)) begin errors++; $display("FAIL fill_word%0d got %0h want %0h", k, got[k], 700 + k); end
        end
        checks++; if (inFlight !== 17'd32) begin errors++; $display("FAIL fill_inFlight got %0d want 32", inFlight); end
        ack(32);
    endtask

    task automatic test_ack_err;
        push(16, 800, 0); drain();
        checks++; if (inFlight !== 17'd16) begin errors++; $display("FAIL ackerr_pre got %0d want 16", inFlight); end
        ack(20);
        checks++; if (inFlight !== 17'd0) begin errors++; $display("FAIL ackerr_clamp got %0d want 0", inFlight); end
        checks++; if (ackErr !== 1'b1) begin errors++; $display("FAIL ackerr_flag got %b want 1", ackErr); end
        tick();
        checks++; if (ackErr !== 1'b1) begin errors++; $display("FAIL ackerr_sticky got %b want 1", ackErr); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit saw = 0;
        oReady = 1;
        push(16, 900, 0);
        while (!(oValid && !oSop) && n < 50) begin tick(); n++; end
        repeat (3) tick();
        reset = 1; tick();
        checks++; if (oValid !== 1'b0 || oSop !== 1'b0 || oEop !== 1'b0 || oData !== '0) begin errors++; $display("FAIL rstmid_out got v=%b sop=%b eop=%b %0h want 0", oValid, oSop, oEop, oData); end
        checks++; if (srcReady !== 1'b0 || inFlight !== 17'd0 || ackErr !== 1'b0) begin errors++; $display("FAIL rstmid_state got rdy=%b if=%0d err=%b want 0/0/0", srcReady, inFlight, ackErr); end
        reset = 0; tick();
        checks++; if (srcReady !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", srcReady); end
        repeat (300) begin tick(); if (oValid) saw = 1; end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_discard got output want none"); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 4000; c++) begin
            checks++; if (srcReady !== expReady) begin errors++; $display("FAIL rnd_srcReady cyc %0d got %b want %b", c, srcReady, expReady); end
            checks++; if (oValid !== expValid) begin errors++; $display("FAIL rnd_oValid cyc %0d got %b want %b", c, oValid, expValid); end
            if (expValid) begin
                checks++; if (oSop !== expSop || oEop !== expEop || oData !== expData) begin
                    errors++; $display("FAIL rnd_beat cyc %0d got sop=%b eop=%b %0h want sop=%b eop=%b %0h", c, oSop, oEop, oData, expSop, expEop, expData);
                end
            end
            checks++; if (inFlight !== 17'(mInFl) || ackErr !== mErr) begin errors++; $display("FAIL rnd_credit cyc %0d got %0d/%b want %0d/%b", c, inFlight, ackErr, mInFl, mErr); end
            srcValid = $urandom % 3 != 0;
            for (int j = 0; j < DW / 32; j++) srcData[j*32 +: 32] = $urandom;
            srcEob = $urandom % 10 == 0;
            oReady = $urandom % 4 != 0;
            ackValid = mInFl > 0 && $urandom % 8 == 0;
            ackLen = ackValid ? 18'($urandom_range(1, mInFl)) : '0;
            tick();
        end
        srcValid = 0; ackValid = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_packet();
        test_eob();
        test_timeout();
        test_window();
        test_backpressure();
        test_full_buffer();
        test_ack_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
